// File: rtl/enc_resource_arbiter.sv
// Single-owner arbiter: lowest-index-first grant held until release, owner drop or hold timeout.
// Define ARB_ROUND_ROBIN_EN to rotate priority after the last owner; the port is named rel because release is a reserved word.
module enc_resource_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int IDX_W    = 2,
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               rel,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               timeout
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD > 0 ? MAX_HOLD - 1 : 0);
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MAX_HOLD);
  localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(NUM_REQ - 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   hold_cnt, hold_cnt_nxt;
  logic [IDX_W-1:0]   last_grant, last_grant_nxt;
  logic [NUM_REQ-1:0] gnt_nxt;
  logic [IDX_W-1:0]   gnt_idx_nxt;
  logic               gnt_valid_nxt;
  logic               timeout_nxt;
  logic [IDX_W-1:0]   winner;

  // Scan from lowest priority to highest so the last hit is the winner.
  always_comb begin
    winner = '0;
`ifdef ARB_ROUND_ROBIN_EN
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[(int'(last_grant) + 1 + k) % NUM_REQ])
        winner = IDX_W'((int'(last_grant) + 1 + k) % NUM_REQ);
    end
`else
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[k]) winner = IDX_W'(k);
    end
`endif
  end

  // NOTE: every signal gets a default first so no path through this block infers a latch.
  always_comb begin
    state_nxt      = state;
    hold_cnt_nxt   = hold_cnt;
    last_grant_nxt = last_grant;
    gnt_nxt        = gnt;
    gnt_idx_nxt    = gnt_idx;
    gnt_valid_nxt  = gnt_valid;
    timeout_nxt    = 1'b0;

    unique case (state)
      IDLE: begin
        if (|req) begin
          state_nxt       = BUSY;
          gnt_nxt         = '0;
          gnt_nxt[winner] = 1'b1;
          gnt_idx_nxt     = winner;
          gnt_valid_nxt   = 1'b1;
          hold_cnt_nxt    = '0;
          last_grant_nxt  = winner;
        end
      end
      BUSY: begin
        if (rel || !req[gnt_idx] || (MAX_HOLD != 0 && hold_cnt == HOLD_LAST)) begin
          state_nxt     = IDLE;
          gnt_nxt       = '0;
          gnt_idx_nxt   = '0;
          gnt_valid_nxt = 1'b0;
          hold_cnt_nxt  = '0;
          // Release and owner drop take precedence, so only a pure expiry pulses.
          timeout_nxt   = !rel && req[gnt_idx];
        end else if (hold_cnt != HOLD_MAX) begin
          hold_cnt_nxt = hold_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      last_grant <= LAST_RST;
      gnt        <= '0;
      gnt_idx    <= '0;
      gnt_valid  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_nxt;
      hold_cnt   <= hold_cnt_nxt;
      last_grant <= last_grant_nxt;
      gnt        <= gnt_nxt;
      gnt_idx    <= gnt_idx_nxt;
      gnt_valid  <= gnt_valid_nxt;
      timeout    <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_enc_resource_arbiter.sv
// Randomised and directed bench for enc_resource_arbiter against a tenure-level reference model.
// Works in both the fixed-priority build and the ARB_ROUND_ROBIN_EN build.
module tb_enc_resource_arbiter;

  localparam int N    = 4;
  localparam int HOLD = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic         rel = 1'b0;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_idx;
  logic         gnt_valid;
  logic         timeout;

  int checks   = 0;
  int failures = 0;

  // Reference model: who owns the resource, how long they have held it, who went last.
  bit m_busy    = 1'b0;
  int m_owner   = 0;
  int m_tenure  = 0;
  int m_last    = N - 1;
  bit m_timeout = 1'b0;

  enc_resource_arbiter #(.NUM_REQ(N), .IDX_W(2), .MAX_HOLD(HOLD), .CNT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .rel       (rel),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int last);
    int  w     = 0;
    bit  found = 1'b0;
    for (int k = 0; k < N; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (!found && r[(last + 1 + k) % N]) begin
        w     = (last + 1 + k) % N;
        found = 1'b1;
      end
`else
      if (!found && r[k]) begin
        w     = k;
        found = 1'b1;
      end
`endif
    end
    return w;
  endfunction

  task automatic model_edge(input logic [N-1:0] r, input bit rl, input bit rs);
    m_timeout = 1'b0;
    if (rs) begin
      m_busy = 1'b0; m_owner = 0; m_tenure = 0; m_last = N - 1;
    end else if (!m_busy) begin
      if (r != 0) begin
        m_owner  = pick(r, m_last);
        m_last   = m_owner;
        m_busy   = 1'b1;
        m_tenure = 1;
      end
    end else if (rl || !r[m_owner]) begin
      m_busy = 1'b0; m_owner = 0;
    end else if (HOLD != 0 && m_tenure == HOLD) begin
      m_busy = 1'b0; m_owner = 0; m_timeout = 1'b1;
    end else begin
      m_tenure++;
    end
  endtask

  // One clock: apply inputs, advance the model across the edge, compare just after it.
  task automatic step(input logic [N-1:0] r, input bit rl, input bit rs);
    logic [N-1:0] exp_gnt;
    req = r; rel = rl; rst = rs;
    @(posedge clk);
    model_edge(r, rl, rs);
    #1;
    exp_gnt = m_busy ? N'(1) << m_owner : '0;
    check("gnt",       32'(gnt),       32'(exp_gnt));
    check("gnt_idx",   32'(gnt_idx),   32'(m_owner));
    check("gnt_valid", 32'(gnt_valid), 32'(m_busy));
    check("timeout",   32'(timeout),   32'(m_timeout));
  endtask

  task automatic lit(input string name, input logic [N-1:0] eg, input int ei, input bit ev, input bit et);
    check({name, ".gnt"},       32'(gnt),       32'(eg));
    check({name, ".gnt_idx"},   32'(gnt_idx),   32'(ei));
    check({name, ".gnt_valid"}, 32'(gnt_valid), 32'(ev));
    check({name, ".timeout"},   32'(timeout),   32'(et));
  endtask

  initial begin
    logic [N-1:0] r;
    int           valid_cycles;
    int           exp_seq [5];
`ifdef ARB_ROUND_ROBIN_EN
    exp_seq = '{1, -1, 3, -1, 1};
`else
    exp_seq = '{1, -1, 1, -1, 1};
`endif

    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b1);
    lit("reset", 4'b0000, 0, 1'b0, 1'b0);

    // Single request, one-cycle latency, release.
    step('0, 1'b0, 1'b0);
    lit("idle", 4'b0000, 0, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b0);
    lit("single_grant", 4'b0100, 2, 1'b1, 1'b0);
    step(4'b0100, 1'b1, 1'b0);
    lit("single_release", 4'b0000, 0, 1'b0, 1'b0);

    // Reset in the middle of a tenure, then priority restarts from index 0.
    step(4'b0100, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b1);
    lit("reset_mid", 4'b0000, 0, 1'b0, 1'b0);
    step(4'b1010, 1'b0, 1'b0);
    lit("post_reset", 4'b0010, 1, 1'b1, 1'b0);
    step(4'b1010, 1'b0, 1'b1);

    // Contention with release after every grant.
    for (int i = 0; i < 5; i++) begin
      step(4'b1010, (i % 2) == 1, 1'b0);
      if (exp_seq[i] < 0) lit("contend_gap", 4'b0000, 0, 1'b0, 1'b0);
      else lit("contend_grant", N'(1) << exp_seq[i], exp_seq[i], 1'b1, 1'b0);
    end
    step(4'b0000, 1'b1, 1'b0);

    // No preemption by a higher-priority request.
    step(4'b0100, 1'b0, 1'b0);
    step(4'b0101, 1'b0, 1'b0);
    step(4'b0101, 1'b0, 1'b0);
    lit("no_preempt", 4'b0100, 2, 1'b1, 1'b0);
    step(4'b0101, 1'b1, 1'b0);
    lit("preempt_gap", 4'b0000, 0, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b0);
    lit("after_release", 4'b0001, 0, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);

    // Timeout: exactly HOLD valid cycles, pulse as grant drops, re-grant one cycle later.
    valid_cycles = 0;
    for (int i = 0; i < HOLD; i++) begin
      step(4'b0001, 1'b0, 1'b0);
      if (gnt_valid) valid_cycles++;
    end
    step(4'b0001, 1'b0, 1'b0);
    lit("timeout_fire", 4'b0000, 0, 1'b0, 1'b1);
    check("timeout_len", 32'(valid_cycles), 32'(HOLD));
    step(4'b0001, 1'b0, 1'b0);
    lit("timeout_regrant", 4'b0001, 0, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    lit("owner_drop", 4'b0000, 0, 1'b0, 1'b0);

    // Release coincident with the expiry cycle wins; no pulse.
    for (int i = 0; i < HOLD; i++) step(4'b0001, 1'b0, 1'b0);
    step(4'b0001, 1'b1, 1'b0);
    lit("release_vs_timeout", 4'b0000, 0, 1'b0, 1'b0);

    // Release in IDLE is ignored; the grant still proceeds.
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0010, 1'b1, 1'b0);
    lit("idle_release", 4'b0010, 1, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b0);

    // Random traffic; requests tend to persist so holds and timeouts occur.
    r = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) r = N'($urandom);
      step(r, $urandom_range(0, 7) == 0, $urandom_range(0, 99) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
